oc8051_ri_access: RTL and testbench

//  Indirect-operand access sequencer for @Ri instructions (MOV @Ri, MOVX @Ri).

---
 rtl/oc8051_ri_access.sv | 147 ++++++++++++++
 tb/tb_oc8051_ri_access.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/oc8051_ri_access.sv
// Indirect-operand (@Ri) access sequencer: resolves R0/R1 pointer, then performs one
// internal-RAM or external-bus (MOVX) read/write and reports completion.
module oc8051_ri_access #(
    parameter int unsigned EXT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic        sel,
    input  logic [7:0]  wdat,
    input  logic        flush,
    output logic        ri_sel,
    input  logic [7:0]  ri_in,
    output logic        ram_rd_en,
    output logic [7:0]  ram_rd_addr,
    input  logic [7:0]  ram_rd_data,
    output logic        ram_wr_en,
    output logic [7:0]  ram_wr_addr,
    output logic [7:0]  ram_wr_data,
    input  logic [7:0]  p2_in,
    output logic        ext_stb,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    input  logic        ext_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdat
);

    localparam logic [7:0] TMAX = 8'(EXT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        XSTB = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_r;
    logic [7:0]  wdat_r;
    logic [7:0]  addr_r;
    logic [7:0]  p2_r;
    logic [7:0]  tcnt;
    logic        tmo;

    assign tmo = (tcnt == TMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) state_nx = ADDR;
            ADDR: begin
                case (op_r)
                    2'b00:   state_nx = RD;
                    2'b01:   state_nx = WR;
                    default: state_nx = XSTB;
                endcase
            end
            RD:   state_nx = CAP;
            CAP:  state_nx = IDLE;
            WR:   state_nx = IDLE;
            XSTB: if (ext_ack || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Strobes decode from state only, so they drop the instant rst resets the state.
    always_comb begin
        busy        = (state != IDLE);
        ram_rd_en   = (state == RD);
        ram_wr_en   = (state == WR);
        ext_stb     = (state == XSTB);
        ext_we      = (state == XSTB) && op_r[0];
        ram_rd_addr = addr_r;
        ram_wr_addr = addr_r;
        ram_wr_data = wdat_r;
        ext_addr    = {p2_r, addr_r};
        ext_dout    = wdat_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= '0;
            wdat_r <= '0;
            addr_r <= '0;
            p2_r   <= '0;
            tcnt   <= '0;
            ri_sel <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            rdat   <= '0;
        end else begin
            done <= 1'b0;
            // A flush suppresses every register update, including done and rdat.
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            op_r   <= op;
                            ri_sel <= sel;
                            wdat_r <= wdat;
                            err    <= 1'b0;
                        end
                    end
                    ADDR: begin
                        addr_r <= ri_in;
                        p2_r   <= p2_in;
                        tcnt   <= '0;
                    end
                    CAP: begin
                        rdat <= ram_rd_data;
                        done <= 1'b1;
                    end
                    WR: done <= 1'b1;
                    XSTB: begin
                        if (ext_ack) begin
                            if (!op_r[0]) rdat <= ext_din;
                            done <= 1'b1;
                            err  <= 1'b0;
                        end else if (tmo) begin
                            if (!op_r[0]) rdat <= 8'hFF;
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oc8051_ri_access.sv
// Directed self-checking bench for oc8051_ri_access with small RAM/pointer models.
module tb_oc8051_ri_access;

    logic        clk = 1'b0;
    logic        rst, req, sel, flush, ext_ack;
    logic [1:0]  op;
    logic [7:0]  wdat, ri_in, ram_rd_data, p2_in, ext_din;
    logic        ri_sel, ram_rd_en, ram_wr_en, ext_stb, ext_we, busy, done, err;
    logic [7:0]  ram_rd_addr, ram_wr_addr, ram_wr_data, ext_dout, rdat;
    logic [15:0] ext_addr;

    logic [7:0]  r0, r1;
    logic [7:0]  ram [256];
    int          wr_cnt, stb_cnt, done_cnt;
    int          errors, checks;
    int          s_stb, s_wr, s_done;

    always #5 clk = ~clk;

    oc8051_ri_access #(.EXT_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .sel(sel), .wdat(wdat),
        .flush(flush), .ri_sel(ri_sel), .ri_in(ri_in),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .p2_in(p2_in), .ext_stb(ext_stb), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_dout(ext_dout), .ext_din(ext_din), .ext_ack(ext_ack),
        .busy(busy), .done(done), .err(err), .rdat(rdat)
    );

    assign ri_in = ri_sel ? r1 : r0;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
        if (ram_wr_en) wr_cnt = wr_cnt + 1;
        if (ext_stb)   stb_cnt = stb_cnt + 1;
        if (done)      done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request at the next edge (E0) and returns just after it.
    task automatic start(input logic [1:0] o, input logic s, input logic [7:0] w);
        op = o; sel = s; wdat = w; req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        wr_cnt = 0; stb_cnt = 0; done_cnt = 0; errors = 0; checks = 0;
        ram_rd_data = '0;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        rst = 1'b1; req = 0; op = 0; sel = 0; wdat = 0; flush = 0;
        ext_ack = 0; ext_din = 0; p2_in = 0; r0 = 0; r1 = 0;
        #23;
        check("rst_busy", busy, 0);
        check("rst_outs", {done, err, ext_stb, ram_rd_en, ram_wr_en, ri_sel}, 0);
        check("rst_rdat", rdat, 8'h00);
        tick(); rst = 1'b0; tick();

        // 1: IRAM read via R1
        r1 = 8'h3C; ram[8'h3C] = 8'hA5;
        start(2'b00, 1'b1, 8'h00);
        check("t1_risel", ri_sel, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_rden", ram_rd_en, 1);
        check("t1_rdaddr", ram_rd_addr, 8'h3C);
        tick();
        check("t1_rden_off", {ram_rd_en, done}, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_rdat", rdat, 8'hA5);
        check("t1_err", err, 0);
        tick();
        check("t1_done_pulse", {done, busy}, 0);

        // 2: IRAM write to upper address via R0
        r0 = 8'hF0; s_wr = wr_cnt;
        start(2'b01, 1'b0, 8'h5A);
        tick();
        check("t2_wren", ram_wr_en, 1);
        check("t2_wr", {ram_wr_addr, ram_wr_data}, 16'hF05A);
        tick();
        check("t2_done", done, 1);
        check("t2_rdat_hold", rdat, 8'hA5);
        check("t2_ram", ram[8'hF0], 8'h5A);
        check("t2_wrcnt", wr_cnt - s_wr, 1);

        // 3: XRAM read, ack in fourth strobe cycle
        tick();
        p2_in = 8'h12; r0 = 8'h34;
        start(2'b10, 1'b0, 8'h00);
        tick();
        check("t3_stb", ext_stb, 1);
        check("t3_addr", ext_addr, 16'h1234);
        check("t3_we", ext_we, 0);
        tick(); tick(); tick();
        ext_ack = 1; ext_din = 8'h77;
        tick();
        ext_ack = 0;
        check("t3_done", {done, err, ext_stb}, 3'b100);
        check("t3_rdat", rdat, 8'h77);

        // 4a: XRAM write timeout
        tick();
        s_stb = stb_cnt;
        start(2'b11, 1'b0, 8'hC3);
        tick();
        check("t4_we", ext_we, 1);
        check("t4_dout", ext_dout, 8'hC3);
        for (int i = 0; i < 40 && !done; i++) tick();
        check("t4_done", done, 1);
        check("t4_err", err, 1);
        check("t4_stbcnt", stb_cnt - s_stb, 15);
        check("t4_rdat_hold", rdat, 8'h77);
        // 4b: read timeout returns FF; err cleared on acceptance
        tick();
        start(2'b10, 1'b0, 8'h00);
        check("t4_err_clr", err, 0);
        for (int i = 0; i < 40 && !done; i++) tick();
        check("t4r_done", {done, err}, 2'b11);
        check("t4r_rdat", rdat, 8'hFF);
        // 4c: ack on the final allowed cycle wins
        tick();
        start(2'b10, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("t4c_last", {ext_stb, done}, 2'b10);
        ext_ack = 1; ext_din = 8'h9A;
        tick();
        ext_ack = 0;
        check("t4c_done", {done, err}, 2'b10);
        check("t4c_rdat", rdat, 8'h9A);

        // 5: flush in RD and in XSTB
        tick();
        s_done = done_cnt;
        start(2'b00, 1'b1, 8'h00);
        tick();
        flush = 1; tick(); flush = 0;
        check("t5_rd_flush", {busy, ram_rd_en}, 0);
        start(2'b10, 1'b0, 8'h00);
        tick(); tick();
        flush = 1; tick(); flush = 0;
        check("t5_x_flush", {busy, ext_stb}, 0);
        tick(); tick();
        check("t5_no_done", done_cnt - s_done, 0);
        check("t5_rdat", rdat, 8'h9A);
        // flush beats req
        flush = 1; start(2'b00, 1'b0, 8'h00); flush = 0;
        check("t5_flush_req", busy, 0);
        // req held through busy is ignored, then accepted on the done cycle
        op = 2'b00; sel = 1'b1; req = 1'b1;
        tick();
        op = 2'b01; sel = 1'b0; wdat = 8'h11;
        tick();
        check("t5_ign_rd", ram_rd_en, 1);
        tick(); tick();
        check("t5_b2b_done", {done, rdat}, {1'b1, 8'hA5});
        tick();
        req = 1'b0;
        check("t5_b2b_acc", {busy, done}, 2'b10);
        tick();
        check("t5_b2b_wr", {ram_wr_en, ram_wr_addr, ram_wr_data}, {1'b1, 8'h34, 8'h11});
        tick();
        check("t5_b2b_wdone", done, 1);

        // 6: async reset mid-XSTB
        tick();
        start(2'b10, 1'b0, 8'h00);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst", {busy, ext_stb, done, err, ri_sel, rdat}, 0);
        tick(); rst = 1'b0; tick();
        start(2'b00, 1'b1, 8'h00);
        for (int i = 0; i < 10 && !done; i++) tick();
        check("t6_after", {done, err, rdat}, {2'b10, 8'hA5});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
